ou_display_seq: RTL and testbench

//  Sequencing controller for the calculator output unit.
//  - Captures an 8-bit two's-complement result on a LoadOU strobe.
//  - Converts it to sign + magnitude, then runs an iterative double-dabble to produce

---
 rtl/ou_pkg.sv | 24 ++
 rtl/bcd_dabble_step.sv | 31 +++
 rtl/ou_display_seq.sv | 155 +++++++++++++++
 tb/tb_ou_display_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ou_pkg.sv
// Shared definitions for the calculator output unit.
//  - state_t     : sequencing FSM encoding (IDLE / CONV / COMMIT)
//  - ITER_LAST   : value of the iteration counter on the final double-dabble step
//  - BCD_ADJ_*   : double-dabble nibble adjust threshold and offset
//  - mag_of()    : two's-complement magnitude of an 8-bit result
package ou_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [2:0] ITER_LAST      = 3'd7;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_OFFSET = 4'd3;

  // Magnitude as an unsigned 8-bit value. -128 maps to 8'd128, which still
  // fits, so the 9-bit intermediate never needs its top bit.
  function automatic logic [7:0] mag_of(input logic [7:0] v);
    return v[7] ? (~v + 8'd1) : v;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational double-dabble iteration.
//  bcd_in  [8:0] : current BCD accumulator without its top bit
//                  ({hundreds[0], tens, ones}); hundreds[1] is shifted out
//                  of the accumulator and therefore not needed here
//  mag_in  [7:0] : remaining binary magnitude, MSB is shifted in next
//  bcd_out [9:0] : adjusted and shifted accumulator {hundreds, tens, ones}
//  mag_out [7:0] : magnitude shifted left by one
module bcd_dabble_step
  import ou_pkg::*;
(
  input  logic [8:0] bcd_in,
  input  logic [7:0] mag_in,
  output logic [9:0] bcd_out,
  output logic [7:0] mag_out
);

  logic [3:0] ones_adj;
  logic [3:0] tens_adj;

  // The hundreds digit never exceeds 1 for an 8-bit magnitude, so it never
  // reaches the adjust threshold and needs no adder.
  always_comb begin
    ones_adj = (bcd_in[3:0] >= BCD_ADJ_THRESH) ? bcd_in[3:0] + BCD_ADJ_OFFSET
                                               : bcd_in[3:0];
    tens_adj = (bcd_in[7:4] >= BCD_ADJ_THRESH) ? bcd_in[7:4] + BCD_ADJ_OFFSET
                                               : bcd_in[7:4];
    bcd_out  = {bcd_in[8], tens_adj, ones_adj, mag_in[7]};
    mag_out  = {mag_in[6:0], 1'b0};
  end

endmodule

// File: rtl/ou_display_seq.sv
// Sequencing controller for the calculator output unit.
// Captures a two's-complement result on LoadOU, converts it to sign plus
// three BCD digits with an iterative double-dabble, and publishes digits,
// sign and leading-zero blank flags with a one-cycle Done pulse. One pending
// result is held so that loads arriving while busy are not lost.
//  CLK      : clock, rising edge
//  Reset    : synchronous active-high reset
//  LoadOU   : load strobe, Din sampled on every edge where it is high
//  Din      : result from the datapath
//  Busy     : conversion or commit in progress (covers the Done cycle)
//  Done     : one-cycle pulse, outputs updated on the same edge
//  ONES/TENS/HUNDREDS : registered BCD digits
//  Neg      : displayed value is negative
//  BlankH/BlankT : hundreds / tens digit is a leading zero (BLANK_LZ=1 only)
module ou_display_seq
  import ou_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             LoadOU,
  input  logic [WIDTH-1:0] Din,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       ONES,
  output logic [3:0]       TENS,
  output logic [1:0]       HUNDREDS,
  output logic             Neg,
  output logic             BlankH,
  output logic             BlankT
);

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  it;
  logic [9:0]  bcd;
  logic [7:0]  mag;
  logic        sr_neg;
  logic        pend_valid;
  logic [7:0]  pend_din;
  logic        start;
  logic [7:0]  start_din;
  logic [9:0]  step_bcd;
  logic [7:0]  step_mag;

  bcd_dabble_step u_step (
    .bcd_in  (bcd[8:0]),
    .mag_in  (mag),
    .bcd_out (step_bcd),
    .mag_out (step_mag)
  );

  // A new conversion starts from IDLE on a load, or straight out of COMMIT.
  // On the COMMIT edge a fresh load beats the pending entry (last writer wins).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned, which would infer a latch.
    start     = 1'b0;
    start_din = Din;
    case (state)
      IDLE:    start = LoadOU;
      COMMIT: begin
        start = LoadOU | pend_valid;
        if (!LoadOU) start_din = pend_din;
      end
      default: ;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (LoadOU) state_nxt = CONV;
      CONV:    if (it == ITER_LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Done is high in the cycle after COMMIT; folding it in keeps Busy high
  // through E9..E10 and gapless when a new conversion starts at COMMIT.
  always_comb begin
    Busy = (state != IDLE) | Done;
  end

  // ---------------- Datapath: shift register, counter, pending ----------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      // NOTE: the shift register and pending data are always overwritten before
      // use; they are reset anyway so an aborted conversion leaves nothing stale.
      it         <= '0;
      bcd        <= '0;
      mag        <= '0;
      sr_neg     <= 1'b0;
      pend_valid <= 1'b0;
      pend_din   <= '0;
    end else begin
      if (start) begin
        it     <= '0;
        bcd    <= '0;
        mag    <= mag_of(start_din);
        sr_neg <= start_din[7];
      end else if (state == CONV) begin
        it  <= it + 3'd1;
        bcd <= step_bcd;
        mag <= step_mag;
      end

      // Loads during CONV park in the single pending slot; COMMIT always
      // drains it (either consumed or superseded by a same-edge load).
      if (state == CONV && LoadOU) begin
        pend_valid <= 1'b1;
        pend_din   <= Din;
      end else if (state == COMMIT) begin
        pend_valid <= 1'b0;
      end
    end
  end

  // ---------------- Output registers ----------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      Done     <= 1'b0;
      ONES     <= '0;
      TENS     <= '0;
      HUNDREDS <= '0;
      Neg      <= 1'b0;
      BlankH   <= BLANK_LZ;
      BlankT   <= BLANK_LZ;
    end else begin
      Done <= (state == COMMIT);
      if (state == COMMIT) begin
        HUNDREDS <= bcd[9:8];
        TENS     <= bcd[7:4];
        ONES     <= bcd[3:0];
        Neg      <= sr_neg;
        BlankH   <= BLANK_LZ & (bcd[9:8] == 2'd0);
        BlankT   <= BLANK_LZ & (bcd[9:8] == 2'd0) & (bcd[7:4] == 4'd0);
      end
    end
  end

endmodule

// File: tb/tb_ou_display_seq.sv
// Bench for ou_display_seq: two instances (BLANK_LZ=1 and BLANK_LZ=0) share
// stimulus; a transaction-level model predicts every output each cycle, and
// directed scenarios add literal expectations.
module tb_ou_display_seq;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       LoadOU = 1'b0;
  logic [7:0] Din = 8'd0;

  logic       b1, d1, n1, bh1, bt1;
  logic [3:0] o1, t1;
  logic [1:0] h1;
  logic       b0, d0, n0, bh0, bt0;
  logic [3:0] o0, t0;
  logic [1:0] h0;

  ou_display_seq #(.WIDTH(8), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .Reset(Reset), .LoadOU(LoadOU), .Din(Din),
    .Busy(b1), .Done(d1), .ONES(o1), .TENS(t1), .HUNDREDS(h1),
    .Neg(n1), .BlankH(bh1), .BlankT(bt1)
  );

  ou_display_seq #(.WIDTH(8), .BLANK_LZ(1'b0)) dut0 (
    .CLK(CLK), .Reset(Reset), .LoadOU(LoadOU), .Din(Din),
    .Busy(b0), .Done(d0), .ONES(o0), .TENS(t0), .HUNDREDS(h0),
    .Neg(n0), .BlankH(bh0), .BlankT(bt0)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model (transaction level) ----------------
  // A conversion started at edge E0 commits at E0+9. One pending slot,
  // last writer wins; a load on the commit edge starts at once.
  bit         m_active, m_pend_v, m_done;
  int         m_rem;
  logic [7:0] m_val, m_pend;
  int         m_ones, m_tens, m_hund;
  bit         m_neg, m_bh, m_bt;

  function automatic void m_start(input logic [7:0] v);
    m_active = 1'b1;
    m_rem    = 9;
    m_val    = v;
  endfunction

  function automatic void m_publish(input logic [7:0] v);
    int a;
    a      = v[7] ? 256 - int'(v) : int'(v);
    m_hund = a / 100;
    m_tens = (a / 10) % 10;
    m_ones = a % 10;
    m_neg  = v[7];
    m_bh   = (m_hund == 0);
    m_bt   = m_bh && (m_tens == 0);
  endfunction

  always @(posedge CLK) begin
    if (Reset) begin
      m_active = 1'b0; m_pend_v = 1'b0; m_done = 1'b0; m_rem = 0;
      m_ones = 0; m_tens = 0; m_hund = 0; m_neg = 1'b0;
      m_bh = 1'b1; m_bt = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_active && m_rem == 1) begin
        m_publish(m_val);
        m_done   = 1'b1;
        m_active = 1'b0;
        if (LoadOU)        m_start(Din);
        else if (m_pend_v) m_start(m_pend);
        m_pend_v = 1'b0;
      end else if (m_active) begin
        m_rem--;
        if (LoadOU) begin
          m_pend   = Din;
          m_pend_v = 1'b1;
        end
      end else if (LoadOU) begin
        m_start(Din);
      end
    end
  end

  // Compare process: outputs are registered, sample on the falling edge.
  always @(negedge CLK) begin
    check("busy",   b1,  m_active || m_done);
    check("done",   d1,  m_done);
    check("hund",   h1,  m_hund);
    check("tens",   t1,  m_tens);
    check("ones",   o1,  m_ones);
    check("neg",    n1,  m_neg);
    check("blankh", bh1, m_bh);
    check("blankt", bt1, m_bt);
    check("lz0_busy",   b0,  m_active || m_done);
    check("lz0_done",   d0,  m_done);
    check("lz0_digits", {h0, t0, o0}, {m_hund[1:0], m_tens[3:0], m_ones[3:0]});
    check("lz0_neg",    n0,  m_neg);
    check("lz0_blanks", {bh0, bt0}, 2'b00);
  end

  // ---------------- Stimulus helpers ----------------
  task automatic load(input logic [7:0] v);
    LoadOU = 1'b1;
    Din    = v;
    @(posedge CLK);
    #1;
    LoadOU = 1'b0;
    Din    = 8'($urandom);
  endtask

  task automatic wait_done(output int k);
    k = 0;
    do begin
      @(posedge CLK);
      #1;
      k++;
    end while (!d1 && k < 40);
    if (!d1) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_disp(input string name, input int h, input int t, input int o,
                             input bit neg, input bit bh, input bit bt);
    check({name, "_digits"}, {h1, t1, o1}, {h[1:0], t[3:0], o[3:0]});
    check({name, "_neg"},    n1, neg);
    check({name, "_blanks"}, {bh1, bt1}, {bh, bt});
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int k;
    int seen;

    repeat (2) @(posedge CLK);
    #1;
    Reset = 1'b0;
    check("rst_busy", b1, 0);
    check("rst_done", d1, 0);
    expect_disp("rst", 0, 0, 0, 1'b0, 1'b1, 1'b1);
    check("rst_lz0_blanks", {bh0, bt0}, 2'b00);

    // 127: latency and largest positive value
    load(8'h7F);
    wait_done(k);
    check("lat_7f", k, 9);
    expect_disp("v7f", 1, 2, 7, 1'b0, 1'b0, 1'b0);
    @(posedge CLK); #1;

    // -128: magnitude 128 without overflow
    load(8'h80);
    wait_done(k);
    expect_disp("v80", 1, 2, 8, 1'b1, 1'b0, 1'b0);

    // -1: both leading zeros blanked
    load(8'hFF);
    wait_done(k);
    expect_disp("vff", 0, 0, 1, 1'b1, 1'b1, 1'b1);

    // 10: blank behaviour with and without BLANK_LZ
    load(8'h0A);
    wait_done(k);
    expect_disp("v0a", 0, 1, 0, 1'b0, 1'b1, 1'b0);
    check("v0a_lz0_blanks", {bh0, bt0}, 2'b00);
    @(posedge CLK); #1;

    // Back-to-back: 5 at E0, 9 at E3, 42 at E5; 9 is overwritten
    load(8'd5);
    repeat (2) @(posedge CLK);
    #1;
    load(8'd9);
    @(posedge CLK); #1;
    load(8'd42);
    wait_done(k);
    check("b2b_first_lat", k, 4);
    expect_disp("b2b_5", 0, 0, 5, 1'b0, 1'b1, 1'b1);
    wait_done(k);
    check("b2b_second_lat", k, 9);
    expect_disp("b2b_42", 0, 4, 2, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    check("b2b_idle", b1, 0);

    // Load on the COMMIT edge: 99 then -10
    load(8'd99);
    repeat (8) @(posedge CLK);
    #1;
    load(8'hF6);
    check("commit_done", d1, 1);
    expect_disp("commit_99", 0, 9, 9, 1'b0, 1'b1, 1'b0);
    check("commit_busy", b1, 1);
    wait_done(k);
    check("commit_lat", k, 9);
    expect_disp("commit_m10", 0, 1, 0, 1'b1, 1'b1, 1'b0);
    @(posedge CLK); #1;

    // Reset at E4 aborts the conversion
    load(8'h7F);
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    check("abort_busy", b1, 0);
    expect_disp("abort", 0, 0, 0, 1'b0, 1'b1, 1'b1);
    seen = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      seen += int'(d1);
    end
    check("abort_no_done", seen, 0);
    load(8'hC8);
    wait_done(k);
    check("after_abort_lat", k, 9);
    expect_disp("after_abort", 0, 5, 6, 1'b1, 1'b1, 1'b0);

    // Random traffic, occasional resets; the compare process does the checking
    repeat (600) begin
      LoadOU = ($urandom_range(0, 3) == 0);
      Din    = 8'($urandom);
      Reset  = ($urandom_range(0, 199) == 0);
      @(posedge CLK);
      #1;
    end
    LoadOU = 1'b0;
    Reset  = 1'b0;
    repeat (25) @(posedge CLK);
    #1;
    check("final_idle", b1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
